router_pkt_tx: RTL and testbench
================================

// Module: router_pkt_tx
// PURPOSE
//  Packet transmitter for the 1x3 router input port. It accepts a transmit request
//  (addr, length) and a payload byte stream. It buffers the full payload, then drives
//  header {len[5:0],addr[1:0]}, the payload bytes and an XOR parity byte onto the
//  router's packet_valid/data_in interface. It honours router busy and reports the
//  router's err result per packet. Used as the host-side source in front of the router.
// PARAMETERS
//  ERR_WIN  3   cycles after the parity byte during which router err is sampled
//  IFG      2   idle cycles (packet_valid=0) enforced between packets
//  CNT_W    16  width of pkt_count
// PORTS
//  clk             in   1      system clock, all logic on posedge
//  reset           in   1      asynchronous, active-high reset
//  req_valid       in   1      transmit request present
//  req_ready       out  1      block idle, request accepted when req_valid&req_ready
//  req_addr        in   2      destination port 0..2; 3 is illegal
//  req_len         in   6      payload length 1..63; 0 is illegal
//  req_bad_parity  in   1      1: send inverted parity (error injection)
//  pay_valid       in   1      payload byte present
//  pay_data        in   8      payload byte
//  pay_ready       out  1      payload byte accepted when pay_valid&pay_ready
//  busy            in   1      router stall; data_in is sampled only when busy=0
//  err             in   1      router parity-error flag
//  packet_valid    out  1      high during header and payload bytes
//  data_in         out  8      byte to router (registered)
//  tx_done         out  1      1-cycle pulse at end of every request
//  tx_err          out  1      valid with tx_done: err seen, or illegal request
//  pkt_count       out  CNT_W  packets fully sent; wraps at 2^CNT_W
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, packet_valid=0, data_in=0, pay_ready=0,
//   tx_done=0, tx_err=0, pkt_count=0, buffer pointers=0. A packet in flight is abandoned.
//  FSM: IDLE -> LOAD -> HEADER -> PAYLOAD -> PARITY -> ERRWAIT -> GAP -> IDLE.
//  IDLE: req_ready=1. On accept, latch addr, len and bad_parity, and set parity=header.
//   If len=0 or addr=3: no router activity; the next cycle gives tx_done=1, tx_err=1 -> IDLE.
//  LOAD: pay_ready=1 until len bytes are accepted. Store each byte in the buffer.
//   Input gaps (pay_valid=0) are allowed. After the last byte: HEADER.
//  HEADER: packet_valid=1, data_in=header. The state advances on a posedge with busy=0.
//  PAYLOAD: packet_valid=1 with buffer bytes in order. Each advances only on busy=0.
//   While busy=1, data_in and packet_valid hold stable. There are no bubbles: the
//   buffer always holds the next byte.
//  PARITY: packet_valid=0, data_in = XOR(header, payload), inverted if bad_parity.
//   Held while busy=1, then -> ERRWAIT.
//  ERRWAIT: ERR_WIN cycles; tx_err_q |= err. Then tx_done=1, tx_err=tx_err_q,
//   pkt_count++ -> GAP.
//  GAP: IFG cycles idle, then IDLE. err outside ERRWAIT is ignored.
//  req_valid outside IDLE and pay_valid outside LOAD are ignored (ready=0).
//  Latency, busy=0 throughout: header appears on the cycle after the last payload
//   byte is loaded. Frame = len+2 cycles. tx_done comes ERR_WIN cycles after the parity cycle.
// STRUCTURE
//  router_pkg: ADDR_W=2, LEN_W=6, DATA_W=8, MAX_LEN=63, tx_state_t enum,
//   function make_header(len,addr).
//  Sub-module router_tx_buf: 64x8 buffer with write/read pointers.
//   Signals: wr_en, rd_adv, rd_data, clr.
//  Top: FSM, parity accumulator, err window counter, IFG counter.
// TESTING
//  1 addr=2,len=4,payload 11,22,33,44, busy=0 -> data_in 12,11,22,33,44 (pv=1), then
//    56 (pv=0); tx_done, tx_err=0, pkt_count=1.
//  2 same packet, busy=1 for 2 cycles while 0x11 is on data_in -> 0x11 is held 3 cycles,
//    pv high 7 cycles, parity still 56.
//  3 req_bad_parity=1 -> parity byte A9; router model pulses err 2 cycles later
//    -> tx_done with tx_err=1.
//  4 req_len=0, then req_addr=3 -> packet_valid never rises; tx_done+tx_err one cycle
//    after each accept; pkt_count unchanged.
//  5 reset asserted during 2nd payload byte -> pv=0, data_in=0 immediately; after
//    release req_ready=1 and the next packet matches case 1.
//  6 len=63, addr=1, random payload, random busy -> header FD, 63 bytes in order,
//    correct parity, back-to-back requests separated by IFG idle cycles.

Source files
------------

// File: rtl/router_pkt_tx_pkg.sv
// Shared types and constants for the router host-side packet transmitter.
package router_pkt_tx_pkg;

    localparam int unsigned ADDR_W    = 2;
    localparam int unsigned LEN_W     = 6;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned MAX_LEN   = 63;
    localparam int unsigned BUF_DEPTH = MAX_LEN + 1;
    localparam int unsigned PTR_W     = $clog2(BUF_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REJECT,
        S_LOAD,
        S_HEADER,
        S_PAYLOAD,
        S_PARITY,
        S_ERRWAIT,
        S_GAP
    } tx_state_t;

    function automatic logic [DATA_W-1:0] make_header(input logic [LEN_W-1:0]  len,
                                                      input logic [ADDR_W-1:0] addr);
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// Host request/payload, router-side and status signals of the packet transmitter.
interface router_pkt_tx_if
    import router_pkt_tx_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) ();

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic              req_bad_parity;
    logic              pay_valid;
    logic [DATA_W-1:0] pay_data;
    logic              pay_ready;
    logic              busy;
    logic              err;
    logic              packet_valid;
    logic [DATA_W-1:0] data_in;
    logic              tx_done;
    logic              tx_err;
    logic [CNT_W-1:0]  pkt_count;

    modport master (
        input  req_valid, req_addr, req_len, req_bad_parity, pay_valid, pay_data, busy, err,
        output req_ready, pay_ready, packet_valid, data_in, tx_done, tx_err, pkt_count
    );

    modport slave (
        output req_valid, req_addr, req_len, req_bad_parity, pay_valid, pay_data, busy, err,
        input  req_ready, pay_ready, packet_valid, data_in, tx_done, tx_err, pkt_count
    );

endinterface

// File: rtl/router_pkt_tx_buf.sv
// Payload store: bytes are written in arrival order and read back in the same order.
module router_tx_buf
    import router_pkt_tx_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_adv,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
            if (rd_adv) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/router_pkt_tx.sv
// Buffers a whole payload, then sends header, payload and parity to the router,
// honouring busy and reporting the router's err verdict per packet.
module router_pkt_tx
    import router_pkt_tx_pkg::*;
#(
    parameter int unsigned ERR_WIN = 3,
    parameter int unsigned IFG     = 2,
    parameter int unsigned CNT_W   = 16
) (
    input logic             clk,
    input logic             reset,
    router_pkt_tx_if.master bus
);

    localparam int unsigned WAIT_W = 8;

    tx_state_t         state, nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  rem_q;
    logic              bad_q;
    logic [DATA_W-1:0] par_q;
    logic [WAIT_W-1:0] wcnt_q;
    logic              errq;
    logic              pv_q;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              wr_en, rd_adv, clr;
    logic              req_ready, pay_ready, tx_done, tx_err;
    logic [DATA_W-1:0] rd_data;

    router_tx_buf u_buf (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr),
        .wr_en   (wr_en),
        .wr_data (bus.pay_data),
        .rd_adv  (rd_adv),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt       = state;
        req_ready = 1'b0;
        pay_ready = 1'b0;
        tx_done   = 1'b0;
        tx_err    = 1'b0;
        wr_en     = 1'b0;
        rd_adv    = 1'b0;
        clr       = 1'b0;
        unique case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    clr = 1'b1;
                    nxt = (bus.req_len == '0 || bus.req_addr == '1) ? S_REJECT : S_LOAD;
                end
            end
            S_REJECT: begin
                tx_done = 1'b1;
                tx_err  = 1'b1;
                nxt     = S_IDLE;
            end
            S_LOAD: begin
                pay_ready = 1'b1;
                if (bus.pay_valid) begin
                    wr_en = 1'b1;
                    if (rem_q == LEN_W'(1)) nxt = S_HEADER;
                end
            end
            S_HEADER: begin
                if (!bus.busy) begin
                    rd_adv = 1'b1;
                    nxt    = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                // The read pointer already sits on the next byte, so no bubble on advance.
                if (!bus.busy) begin
                    if (rem_q == LEN_W'(1)) nxt = S_PARITY;
                    else                    rd_adv = 1'b1;
                end
            end
            S_PARITY: begin
                if (!bus.busy) nxt = S_ERRWAIT;
            end
            S_ERRWAIT: begin
                if (wcnt_q == WAIT_W'(ERR_WIN - 1)) begin
                    tx_done = 1'b1;
                    tx_err  = errq | bus.err;
                    nxt     = S_GAP;
                end
            end
            S_GAP: begin
                if (wcnt_q == WAIT_W'(IFG - 1)) nxt = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
            len_q  <= '0;
            rem_q  <= '0;
            bad_q  <= 1'b0;
            par_q  <= '0;
            wcnt_q <= '0;
            errq   <= 1'b0;
            pv_q   <= 1'b0;
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        addr_q <= bus.req_addr;
                        len_q  <= bus.req_len;
                        rem_q  <= bus.req_len;
                        bad_q  <= bus.req_bad_parity;
                        par_q  <= make_header(bus.req_len, bus.req_addr);
                    end
                end
                S_LOAD: begin
                    // Parity is folded in while loading so it is ready when payload ends.
                    if (wr_en) begin
                        par_q <= par_q ^ bus.pay_data;
                        rem_q <= rem_q - 1'b1;
                        if (rem_q == LEN_W'(1)) begin
                            pv_q   <= 1'b1;
                            data_q <= make_header(len_q, addr_q);
                        end
                    end
                end
                S_HEADER: begin
                    if (!bus.busy) begin
                        data_q <= rd_data;
                        rem_q  <= len_q;
                    end
                end
                S_PAYLOAD: begin
                    if (!bus.busy) begin
                        if (rem_q == LEN_W'(1)) begin
                            pv_q   <= 1'b0;
                            data_q <= par_q ^ {DATA_W{bad_q}};
                        end else begin
                            data_q <= rd_data;
                            rem_q  <= rem_q - 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    wcnt_q <= '0;
                    errq   <= 1'b0;
                end
                S_ERRWAIT: begin
                    errq   <= errq | bus.err;
                    wcnt_q <= wcnt_q + 1'b1;
                    if (nxt == S_GAP) begin
                        wcnt_q <= '0;
                        cnt_q  <= cnt_q + CNT_W'(1);
                    end
                end
                S_GAP: wcnt_q <= wcnt_q + 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.req_ready    = req_ready;
    assign bus.pay_ready    = pay_ready;
    assign bus.tx_done      = tx_done;
    assign bus.tx_err       = tx_err;
    assign bus.packet_valid = pv_q;
    assign bus.data_in      = data_q;
    assign bus.pkt_count    = cnt_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: directed and randomized packets against a router-side model.
module tb_router_pkt_tx;
    import router_pkt_tx_pkg::*;

    localparam int unsigned ERR_WIN = 3;
    localparam int unsigned IFG     = 2;
    localparam int unsigned CNT_W   = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;

    router_pkt_tx_if #(.CNT_W(CNT_W)) bus ();

    router_pkt_tx #(.ERR_WIN(ERR_WIN), .IFG(IFG), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [7:0] pay [64];
    logic [7:0] frame_q [$];
    logic       done_q [$];
    logic [7:0] par_byte, xr;
    bit         got_par, in_par;
    logic       prev_pv;
    int         par_cyc, pv_start_cyc, done_cyc, err_at;
    int         pv_cycles, held11, pv_rises;
    int         busy_mode, stall_left;
    int         acc_cyc, last_load_cyc;
    int         exp_cnt;

    // Router-side model: captures bytes it would sample, checks parity, answers with err.
    always @(negedge clk) begin
        if (reset) begin
            prev_pv  = 1'b0;
            in_par   = 1'b0;
            bus.busy = 1'b0;
            bus.err  = 1'b0;
        end else begin
            if (bus.tx_done) begin
                done_q.push_back(bus.tx_err);
                done_cyc = cyc;
            end
            bus.err = (cyc == err_at);
            if (busy_mode == 1)
                bus.busy = ($urandom_range(0, 2) == 0);
            else if (busy_mode == 2 && bus.packet_valid && bus.data_in == 8'h11 && stall_left > 0) begin
                bus.busy = 1'b1;
                stall_left--;
            end else
                bus.busy = 1'b0;
            if (bus.packet_valid) begin
                if (!prev_pv) begin
                    pv_rises++;
                    pv_start_cyc = cyc;
                end
                pv_cycles++;
                if (bus.data_in == 8'h11) held11++;
                if (!bus.busy) frame_q.push_back(bus.data_in);
            end else if (prev_pv)
                in_par = 1'b1;
            if (!bus.packet_valid && in_par && !bus.busy) begin
                par_byte = bus.data_in;
                par_cyc  = cyc;
                got_par  = 1'b1;
                in_par   = 1'b0;
                xr = '0;
                foreach (frame_q[i]) xr ^= frame_q[i];
                if (xr != par_byte) err_at = cyc + 2;
            end
            prev_pv = bus.packet_valid;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        frame_q.delete();
        done_q.delete();
        got_par   = 1'b0;
        pv_cycles = 0;
        held11    = 0;
        pv_rises  = 0;
        err_at    = -1;
    endtask

    task automatic start_pkt(input logic [1:0] a, input logic [5:0] l, input logic b, input bit gaps);
        int  n;
        int  i;
        bit  acc;
        bus.req_addr       = a;
        bus.req_len        = l;
        bus.req_bad_parity = b;
        bus.req_valid      = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        acc_cyc = cyc;
        check("req_accept", 32'(bus.req_ready), 1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        if (l != 0 && a != 2'd3) begin
            i = 0;
            n = 0;
            while (i < int'(l) && n < 1000) begin
                if (gaps && $urandom_range(0, 2) == 0) begin
                    bus.pay_valid = 1'b0;
                    @(negedge clk);
                end else begin
                    bus.pay_valid = 1'b1;
                    bus.pay_data  = pay[i];
                    acc = bus.pay_ready;
                    if (acc && i == int'(l) - 1) last_load_cyc = cyc;
                    @(negedge clk);
                    if (acc) i++;
                end
                n++;
            end
            bus.pay_valid = 1'b0;
            check("load_count", i, 32'(l));
        end
    endtask

    task automatic wait_done(output logic e, output int d);
        int n;
        n = 0;
        while (done_q.size() == 0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(done_q.size() != 0), 1);
        if (done_q.size() != 0) e = done_q.pop_front();
        else                    e = 1'bx;
        d = done_cyc;
    endtask

    task automatic check_frame(input logic [1:0] a, input logic [5:0] l, input logic b);
        logic [7:0] exp_q [$];
        logic [7:0] p;
        logic [7:0] got;
        exp_q.push_back(8'(int'(l) * 4 + int'(a)));
        for (int i = 0; i < int'(l); i++) exp_q.push_back(pay[i]);
        p = '0;
        foreach (exp_q[i]) p ^= exp_q[i];
        if (b) p = ~p;
        check("frame_len", frame_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < frame_q.size()) ? frame_q[i] : 8'hxx;
            check($sformatf("byte%0d", i), 32'(got), 32'(exp_q[i]));
        end
        check("parity_seen", 32'(got_par), 1);
        check("parity", 32'(par_byte), 32'(p));
    endtask

    task automatic run_pkt(input logic [1:0] a, input logic [5:0] l, input logic b, input bit gaps);
        logic e;
        int   d;
        int   n;
        clear_mon();
        start_pkt(a, l, b, gaps);
        wait_done(e, d);
        if (l != 0 && a != 2'd3) begin
            check_frame(a, l, b);
            check("hdr_latency", pv_start_cyc, last_load_cyc + 1);
            check("done_latency", d - par_cyc, ERR_WIN);
            check("tx_err", 32'(e), 32'(b));
            exp_cnt++;
            n = 0;
            while (!bus.req_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("ifg", cyc - d, IFG + 1);
        end else begin
            check("rej_latency", d, acc_cyc + 1);
            check("rej_err", 32'(e), 1);
            check("rej_no_pv", pv_rises, 0);
            @(negedge clk);
        end
        check("pkt_count", 32'(bus.pkt_count), exp_cnt);
    endtask

    task automatic load_case1();
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
    endtask

    initial begin
        int n;
        logic [1:0] ra;
        logic [5:0] rl;
        bus.req_valid      = 1'b0;
        bus.req_addr       = '0;
        bus.req_len        = '0;
        bus.req_bad_parity = 1'b0;
        bus.pay_valid      = 1'b0;
        bus.pay_data       = '0;
        busy_mode  = 0;
        stall_left = 0;
        exp_cnt    = 0;
        err_at     = -1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_pv", 32'(bus.packet_valid), 0);
        check("rst_data", 32'(bus.data_in), 0);
        check("rst_pay_ready", 32'(bus.pay_ready), 0);
        check("rst_tx_done", 32'(bus.tx_done), 0);
        check("rst_tx_err", 32'(bus.tx_err), 0);
        check("rst_count", 32'(bus.pkt_count), 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(bus.req_ready), 1);

        // basic packet, then busy stall on first payload byte
        load_case1();
        run_pkt(2'd2, 6'd4, 1'b0, 1'b0);
        check("case1_pv_cycles", pv_cycles, 5);
        busy_mode  = 2;
        stall_left = 2;
        run_pkt(2'd2, 6'd4, 1'b0, 1'b0);
        check("stall_held", held11, 3);
        check("stall_pv_cycles", pv_cycles, 7);
        busy_mode = 0;

        // injected bad parity -> router err -> tx_err
        run_pkt(2'd2, 6'd4, 1'b1, 1'b0);

        // illegal requests
        run_pkt(2'd2, 6'd0, 1'b0, 1'b0);
        run_pkt(2'd3, 6'd4, 1'b0, 1'b0);

        // reset while the second payload byte is on the wire
        clear_mon();
        start_pkt(2'd2, 6'd4, 1'b0, 1'b0);
        n = 0;
        while (!(bus.packet_valid && bus.data_in == 8'h22) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("saw_byte2", 32'(bus.data_in), 32'h22);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_pv", 32'(bus.packet_valid), 0);
        check("mid_rst_data", 32'(bus.data_in), 0);
        check("mid_rst_count", 32'(bus.pkt_count), 0);
        exp_cnt = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(bus.req_ready), 1);
        run_pkt(2'd2, 6'd4, 1'b0, 1'b0);

        // max-length back-to-back packets with random busy and payload gaps
        busy_mode = 1;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 63; i++) pay[i] = 8'($urandom_range(0, 255));
            run_pkt(2'd1, 6'd63, 1'b0, 1'b1);
        end

        // random legal packets
        for (int k = 0; k < 4; k++) begin
            ra = 2'($urandom_range(0, 2));
            rl = 6'($urandom_range(1, 63));
            for (int i = 0; i < 63; i++) pay[i] = 8'($urandom_range(0, 255));
            run_pkt(ra, rl, 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
